// File: rtl/amba_pkg.sv
// Shared AMBA definitions for the AHB arbiter slice: transfer types,
// arbiter state encoding and the master-count ceiling.
package amba_pkg;

  localparam int unsigned MAX_MASTERS = 4;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    ARB_PARK = 2'b00,
    ARB_OWN  = 2'b01,
    ARB_LOCK = 2'b10
  } arb_state_t;

  function automatic logic [MAX_MASTERS-1:0] onehot(input logic [1:0] idx);
    return MAX_MASTERS'(1) << idx;
  endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// Master-side request/grant signals between the AHB masters and the arbiter.
interface ahb_bus_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 4
);

  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  logic [1:0]             HTRANS;
  logic                   HREADY;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [1:0]             HMASTER;
  logic                   HMASTLOCK;

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HREADY,
    input  HGRANT, HMASTER, HMASTLOCK
  );

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HREADY,
    output HGRANT, HMASTER, HMASTLOCK
  );

endinterface

// File: rtl/ahb_bus_arbiter_rr_picker.sv
// Combinational round-robin search: first set request at or after start,
// wrapping modulo N.
module rr_picker
  import amba_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   start,
  output logic [N-1:0] grant,
  output logic [1:0]   index,
  output logic         valid
);

  always_comb begin
    logic [1:0] cidx;
    grant = '0;
    index = '0;
    valid = 1'b0;
    cidx  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cidx = 2'((32'(start) + i) % N);
      if (!valid && req[cidx]) begin
        valid       = 1'b1;
        grant[cidx] = 1'b1;
        index       = cidx;
      end
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter with lock support and a per-tenure beat quantum;
// grant, address-phase owner and lock flag are all registered.
module ahb_bus_arbiter
  import amba_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned QUANTUM        = 16,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input logic              HCLK,
  input logic              HRESET,
  ahb_bus_arbiter_if.slave bus
);

  localparam int unsigned           CW        = (QUANTUM > 2) ? $clog2(QUANTUM) : 1;
  localparam logic [CW-1:0]         CNT_MAX   = CW'(QUANTUM - 1);
  localparam logic [1:0]            DEF_IDX   = 2'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  arb_state_t             state_q, state_d;
  logic [1:0]             owner_q, owner_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [1:0]             master_q, master_d;
  logic                   mlock_q, mlock_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [MAX_MASTERS-1:0] req, lck;
  logic                   owner_req, owner_lock, others_req, beat, rearb;
  logic [1:0]             start;
  logic [NUM_MASTERS-1:0] pick_grant;
  logic [1:0]             pick_idx;
  logic                   pick_valid;

  always_comb begin
    req = '0;
    lck = '0;
    req[NUM_MASTERS-1:0] = bus.HBUSREQ;
    lck[NUM_MASTERS-1:0] = bus.HLOCK;
  end

  assign owner_req  = req[owner_q];
  assign owner_lock = owner_req & lck[owner_q];
  assign others_req = |(req & ~onehot(owner_q));
  assign beat       = bus.HTRANS[1] & (master_q == owner_q);
  assign start      = 2'((32'(owner_q) + 1) % NUM_MASTERS);

  rr_picker #(.N(NUM_MASTERS)) u_picker (
    .req   (bus.HBUSREQ),
    .start (start),
    .grant (pick_grant),
    .index (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    master_d = master_q;
    mlock_d  = mlock_q;
    cnt_d    = cnt_q;
    rearb    = 1'b0;

    if (bus.HREADY) begin
      master_d = owner_q;
      mlock_d  = owner_lock;

      // A lock request wins over quantum expiry on the same edge.
      unique case (state_q)
        ARB_PARK: rearb = 1'b1;
        ARB_OWN:  rearb = !owner_req ||
                          (cnt_q == CNT_MAX && beat && others_req && !owner_lock);
        ARB_LOCK: rearb = !owner_req;
        default:  rearb = 1'b1;
      endcase

      if (rearb) begin
        if (pick_valid) begin
          owner_d = pick_idx;
          grant_d = pick_grant;
          state_d = ARB_OWN;
        end else begin
          owner_d = DEF_IDX;
          grant_d = DEF_GRANT;
          state_d = ARB_PARK;
        end
      end else if (state_q == ARB_OWN && owner_lock) begin
        state_d = ARB_LOCK;
      end else if (state_q == ARB_LOCK && !lck[owner_q]) begin
        state_d = ARB_OWN;
      end

      if (owner_d != owner_q)
        cnt_d = '0;
      else if (beat && cnt_q != CNT_MAX)
        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= ARB_PARK;
      owner_q  <= DEF_IDX;
      grant_q  <= DEF_GRANT;
      master_q <= DEF_IDX;
      mlock_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      master_q <= master_d;
      mlock_q  <= mlock_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.HGRANT    = grant_q;
  assign bus.HMASTER   = master_q;
  assign bus.HMASTLOCK = mlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed and randomized bench for ahb_bus_arbiter, checked each edge
// against a behavioural round-robin model.
module tb_ahb_bus_arbiter;
  import amba_pkg::*;

  localparam int N   = 4;
  localparam int Q   = 4;
  localparam int DEF = 0;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  ahb_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

  ahb_bus_arbiter #(
    .NUM_MASTERS    (N),
    .QUANTUM        (Q),
    .DEFAULT_MASTER (DEF)
  ) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_owner  = DEF;
  int m_master = DEF;
  bit m_mlock  = 1'b0;
  int m_cnt    = 0;
  bit m_park   = 1'b1;
  bit m_locked = 1'b0;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [3:0] r, input logic [3:0] l,
                            input logic [1:0] t, input logic rdy, input logic rst);
    int  nxt, others, c;
    bit  own_req, own_lk, beat, reb, found;
    if (rst) begin
      m_owner = DEF; m_master = DEF; m_mlock = 0; m_cnt = 0; m_park = 1; m_locked = 0;
    end else if (rdy) begin
      own_req = r[m_owner];
      own_lk  = own_req && l[m_owner];
      others  = 0;
      for (int i = 0; i < N; i++) if (i != m_owner && r[i]) others++;
      beat = t[1] && (m_master == m_owner);
      if (m_locked)    reb = !own_req;
      else if (m_park) reb = 1;
      else             reb = !own_req || (m_cnt == Q-1 && beat && others > 0 && !own_lk);
      nxt = m_owner;
      if (reb) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          c = (m_owner + k) % N;
          if (!found && r[c]) begin nxt = c; found = 1; end
        end
        if (!found) nxt = DEF;
        m_park = !found;
        m_locked = 0;
      end else if (m_locked && !l[m_owner]) begin
        m_locked = 0;
      end else if (!m_locked && own_lk) begin
        m_locked = 1;
      end
      if (nxt != m_owner) m_cnt = 0;
      else if (beat && m_cnt < Q-1) m_cnt++;
      m_master = m_owner;
      m_mlock  = own_lk;
      m_owner  = nxt;
    end
  endtask

  task automatic tick(input logic [3:0] r, input logic [3:0] l,
                      input logic [1:0] t, input logic rdy, input logic rst);
    logic [3:0] eg;
    HRESET      = rst;
    bus.HBUSREQ = r;
    bus.HLOCK   = l;
    bus.HTRANS  = t;
    bus.HREADY  = rdy;
    @(posedge HCLK);
    model_edge(r, l, t, rdy, rst);
    #1;
    eg = 4'b0001 << m_owner;
    check("model_grant",  bus.HGRANT, eg);
    check("model_master", {2'b00, bus.HMASTER}, 4'(m_master));
    check("model_mlock",  {3'b000, bus.HMASTLOCK}, {3'b000, m_mlock});
    check("grant_onehot", {3'b000, $onehot(bus.HGRANT)}, 4'b0001);
  endtask

  initial begin
    logic [3:0] r, l;
    logic [1:0] t;
    logic rdy, rst;

    // reset with all requests high
    tick(4'b1111, 4'b0000, HTRANS_IDLE, 1, 1);
    tick(4'b1111, 4'b0000, HTRANS_IDLE, 1, 1);
    check("rst_grant", bus.HGRANT, 4'b0001);
    check("rst_master", {2'b00, bus.HMASTER}, 4'd0);
    check("rst_mlock", {3'b000, bus.HMASTLOCK}, 4'd0);

    // round robin out of PARK
    tick(4'b0110, 4'b0000, HTRANS_IDLE, 1, 0);
    check("rr_grant1", bus.HGRANT, 4'b0010);
    tick(4'b0110, 4'b0000, HTRANS_IDLE, 1, 0);
    check("rr_master1", {2'b00, bus.HMASTER}, 4'd1);
    tick(4'b0100, 4'b0000, HTRANS_IDLE, 1, 0);
    check("rr_grant2", bus.HGRANT, 4'b0100);
    tick(4'b0100, 4'b0000, HTRANS_IDLE, 1, 0);
    check("rr_master2", {2'b00, bus.HMASTER}, 4'd2);

    // quantum expiry on the 4th beat
    tick(4'b0010, 4'b0000, HTRANS_IDLE, 1, 0);
    tick(4'b0010, 4'b0000, HTRANS_IDLE, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick(4'b1010, 4'b0000, HTRANS_SEQ, 1, 0);
      check("q_hold", bus.HGRANT, 4'b0010);
    end
    tick(4'b1010, 4'b0000, HTRANS_SEQ, 1, 0);
    check("q_switch", bus.HGRANT, 4'b1000);

    // locked tenure ignores quantum and competing requests
    tick(4'b0100, 4'b0100, HTRANS_SEQ, 1, 0);
    tick(4'b0100, 4'b0100, HTRANS_SEQ, 1, 0);
    for (int i = 0; i < 20; i++) begin
      tick(4'b0101, 4'b0100, HTRANS_SEQ, 1, 0);
      check("lk_grant", bus.HGRANT, 4'b0100);
      check("lk_mlock", {3'b000, bus.HMASTLOCK}, 4'd1);
    end
    tick(4'b0101, 4'b0000, HTRANS_SEQ, 1, 0);
    check("unlk_grant", bus.HGRANT, 4'b0100);
    tick(4'b0001, 4'b0000, HTRANS_SEQ, 1, 0);
    check("unlk_regrant", bus.HGRANT, 4'b0001);

    // wait states freeze a pending switch
    for (int i = 0; i < 3; i++) begin
      tick(4'b0010, 4'b0000, HTRANS_IDLE, 0, 0);
      check("ws_grant", bus.HGRANT, 4'b0001);
      check("ws_master", {2'b00, bus.HMASTER}, 4'd2);
    end
    tick(4'b0010, 4'b0000, HTRANS_IDLE, 1, 0);
    check("ws_release", bus.HGRANT, 4'b0010);
    check("ws_master0", {2'b00, bus.HMASTER}, 4'd0);

    // park
    tick(4'b0000, 4'b0000, HTRANS_IDLE, 1, 0);
    check("park_grant", bus.HGRANT, 4'b0001);
    tick(4'b0000, 4'b0000, HTRANS_IDLE, 1, 0);
    check("park_master", {2'b00, bus.HMASTER}, 4'd0);

    // reset during a locked tenure
    tick(4'b1000, 4'b1000, HTRANS_NONSEQ, 1, 0);
    check("ml_grant", bus.HGRANT, 4'b1000);
    tick(4'b1000, 4'b1000, HTRANS_SEQ, 1, 0);
    tick(4'b1000, 4'b1000, HTRANS_SEQ, 1, 0);
    check("ml_mlock", {3'b000, bus.HMASTLOCK}, 4'd1);
    tick(4'b1000, 4'b1000, HTRANS_SEQ, 1, 1);
    check("ml_rst_grant", bus.HGRANT, 4'b0001);
    check("ml_rst_master", {2'b00, bus.HMASTER}, 4'd0);
    check("ml_rst_mlock", {3'b000, bus.HMASTLOCK}, 4'd0);
    tick(4'b0000, 4'b0000, HTRANS_IDLE, 1, 0);
    check("ml_park", bus.HGRANT, 4'b0001);

    // randomized traffic against the model
    r = 4'b0000;
    l = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) r = 4'($urandom);
      if ($urandom_range(0, 7) == 0) l = 4'($urandom) & 4'($urandom);
      t   = 2'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      tick(r, l, t, rdy, rst);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
